mem: RTL and testbench
======================

# mem

Memory-access stage of the five-stage RISC-V pipeline, directly downstream of the execute stage via the EX/MEM register. Performs loads and stores as byte-serial transfers on an 8-bit RAM port, assembling and sign/zero-extending load data. Holds the pipeline with `stall_req` until the transfer completes. Non-memory results pass through to MEM/WB with no added latency, and the stage provides a forwarding path back to ID.

## Interface
Parameters:
- `ADDR_W`, 32, byte address width.
- `DATA_W`, 32, register data width.

Ports:
- `clk` in 1, the single clock.
- `rst` in 1, reset: asynchronous, active-high.
- `rd_data_i` in 32, ALU result; for stores, the store data.
- `rd_addr_i` in 5, destination register.
- `rd_enable_i` in 1, destination write enable.
- `load_enable` in 1, instruction is a load.
- `store_enable` in 1, instruction is a store.
- `mem_addr_i` in 32, effective byte address.
- `load_store_type` in 4, one of `EXE_LB/LH/LW/LBU/LHU/SB/SH/SW` (config.vh).
- `ram_rdata` in 8, read byte, valid when `ram_ready`=1.
- `ram_ready` in 1, current byte accepted/returned this cycle.
- `ram_req` out 1, byte access request.
- `ram_wr` out 1, 1=write, 0=read.
- `ram_addr` out 32, byte address.
- `ram_wdata` out 8, write byte.
- `rd_data_o` out 32, result to MEM/WB.
- `rd_addr_o` out 5, destination register to MEM/WB.
- `rd_enable_o` out 1, destination write enable to MEM/WB.
- `stall_req` out 1, hold PC, IF/ID, ID/EX and EX/MEM.
- `mem_fw` out 1, forwarding valid to ID.
- `mem_fw_addr` out 5, forwarded register.
- `mem_fw_data` out 32, forwarded value.

## Operation
- FSM states: IDLE, BUSY, DONE. Byte counter `cnt` is 2 bits. Byte count `n`: B/BU=1, H/HU=2, W=4.
- IDLE:
  - If `load_enable|store_enable`, go to BUSY with `cnt`=0.
  - Otherwise pass-through: `rd_data_o`=`rd_data_i`, `stall_req`=0.
- BUSY:
  - Drives `ram_req`=1, `ram_addr`=`mem_addr_i+cnt` (mod 2^32), `ram_wr`=`store_enable`, `ram_wdata`=`rd_data_i[8*cnt+7:8*cnt]`.
  - On `ram_ready`, a load captures `ram_rdata` into byte `cnt` of the assembly buffer.
  - If `cnt==n-1`, go to DONE; else increment `cnt`.
  - If `ram_ready`=0, hold all outputs.
- DONE:
  - Loads: `rd_data_o` = assembled little-endian value. LB/LH sign-extend; LBU/LHU zero-extend.
  - Stores: `rd_data_o`=0.
  - `stall_req`=0. Return to IDLE at the next edge.
- `stall_req` = (`load_enable|store_enable`) && state≠DONE.
- `rd_addr_o`=`rd_addr_i`. `rd_enable_o`=`rd_enable_i & ~store_enable`.
- `mem_fw`=`rd_enable_o & ~stall_req`. `mem_fw_addr`=`rd_addr_i`. `mem_fw_data`=`rd_data_o`.
- Misaligned addresses are legal (byte-serial); no exception is raised.
- `load_enable` and `store_enable` both high is illegal; load takes priority.
- EX/MEM holds its inputs stable while `stall_req`=1.

## Timing
- Reset:
  - While `rst`=1, every output is 0.
  - FSM goes to IDLE, `cnt`=0, buffer=0, asynchronously.
  - Reset mid-transfer drops `ram_req` immediately. The held instruction restarts from byte 0 after release.
- Pass-through latency: 0 cycles (combinational).
- Memory op with `ram_ready` tied 1:
  - 1 IDLE cycle + n BUSY cycles + 1 DONE cycle.
  - `stall_req` is high for n+1 cycles.
  - LW: 6 cycles, 5 stalled.
- Each `ram_ready`=0 cycle in BUSY adds one cycle.
- `ram_rdata` is sampled at the rising edge where `ram_ready`=1.

## Configuration
- `MEM_EARLY_REQ_EN` defined:
  - In IDLE with a memory op, byte 0 is requested in that same cycle (`ram_req`=1, `ram_addr`=`mem_addr_i`).
  - If `ram_ready`, byte 0 completes and the FSM goes directly to BUSY (`cnt`=1) or DONE (n=1).
  - LW with ready=1 takes 5 cycles, 4 stalled.
- Undefined: behaviour as in Operation, with the IDLE bubble.

## Test plan
- ALU pass-through: `rd_data_i`=0x00001234, `rd_addr_i`=5, `rd_enable_i`=1, no mem op -> `rd_data_o`=0x00001234, `mem_fw`=1, `mem_fw_addr`=5, `stall_req`=0, all in the same cycle.
- LB 0x100 with `ram_rdata`=0x80 -> `rd_data_o`=0xFFFFFF80. LBU -> 0x00000080. Stall lasts 2 cycles.
- LW 0x200 returning bytes 0x11,0x22,0x33,0x44 with ready=1:
  - `ram_addr` steps 0x200..0x203.
  - `rd_data_o`=0x44332211 in DONE.
  - `stall_req` high for 5 cycles.
- SH 0x301, `rd_data_i`=0xAABBCCDD:
  - Writes 0xDD@0x301 then 0xCC@0x302, with `ram_wr`=1.
  - `rd_enable_o`=0 throughout.
- LH with `ram_ready` low for 3 cycles on byte 1 -> `ram_addr` held at addr+1, stall extended by 3 cycles, data correct.
- `rst` pulsed during byte 2 of an LW -> `ram_req`=0 and all outputs 0 immediately. After release, the transfer restarts at byte 0 and completes correctly.

Source files
------------

// File: rtl/mem.sv
// Memory-access pipeline stage: byte-serial loads/stores over an 8-bit RAM port.
// Optional MEM_EARLY_REQ_EN: issue byte 0 from IDLE, removing the IDLE bubble.
module mem #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] rd_data_i,
  input  logic [4:0]        rd_addr_i,
  input  logic              rd_enable_i,
  input  logic              load_enable,
  input  logic              store_enable,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [3:0]        load_store_type,
  input  logic [7:0]        ram_rdata,
  input  logic              ram_ready,
  output logic              ram_req,
  output logic              ram_wr,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  output logic [DATA_W-1:0] rd_data_o,
  output logic [4:0]        rd_addr_o,
  output logic              rd_enable_o,
  output logic              stall_req,
  output logic              mem_fw,
  output logic [4:0]        mem_fw_addr,
  output logic [DATA_W-1:0] mem_fw_data
);

  localparam logic [3:0] EXE_LB  = 4'd0;
  localparam logic [3:0] EXE_LH  = 4'd1;
  localparam logic [3:0] EXE_LW  = 4'd2;
  localparam logic [3:0] EXE_LBU = 4'd3;
  localparam logic [3:0] EXE_LHU = 4'd4;
  localparam logic [3:0] EXE_SB  = 4'd5;
  localparam logic [3:0] EXE_SH  = 4'd6;
  localparam logic [3:0] EXE_SW  = 4'd7;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] buf_q, buf_d;

  logic              mem_op;
  logic              req;
  logic [1:0]        last_cnt;
  logic [DATA_W-1:0] ld_res;

  assign mem_op = load_enable | store_enable;

  // Index of the final byte: n-1 for n = 1, 2 or 4.
  always_comb begin
    last_cnt = 2'd0;
    case (load_store_type)
      EXE_LH, EXE_LHU, EXE_SH: last_cnt = 2'd1;
      EXE_LW, EXE_SW:          last_cnt = 2'd3;
      default:                 last_cnt = 2'd0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    req     = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_op) begin
`ifdef MEM_EARLY_REQ_EN
          req     = 1'b1;
          state_d = BUSY;
          cnt_d   = 2'd0;
          if (ram_ready) begin
            if (load_enable) buf_d[{cnt_q, 3'b000} +: 8] = ram_rdata;
            if (last_cnt == 2'd0) state_d = DONE;
            else                  cnt_d   = 2'd1;
          end
`else
          state_d = BUSY;
          cnt_d   = 2'd0;
`endif
        end
      end
      BUSY: begin
        req = 1'b1;
        if (ram_ready) begin
          if (load_enable) buf_d[{cnt_q, 3'b000} +: 8] = ram_rdata;
          if (cnt_q == last_cnt) state_d = DONE;
          else                   cnt_d   = cnt_q + 2'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = 2'd0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
    end
  end

  always_comb begin
    ld_res = buf_q;
    case (load_store_type)
      EXE_LB:  ld_res = {{(DATA_W-8){buf_q[7]}}, buf_q[7:0]};
      EXE_LBU: ld_res = {{(DATA_W-8){1'b0}}, buf_q[7:0]};
      EXE_LH:  ld_res = {{(DATA_W-16){buf_q[15]}}, buf_q[15:0]};
      EXE_LHU: ld_res = {{(DATA_W-16){1'b0}}, buf_q[15:0]};
      default: ld_res = buf_q;
    endcase
  end

  // Every output is forced to zero while reset is held, including pass-through paths.
  always_comb begin
    ram_req     = req & ~rst;
    ram_wr      = req & ~rst & store_enable & ~load_enable;
    ram_addr    = ram_req ? mem_addr_i + ADDR_W'(cnt_q) : '0;
    ram_wdata   = ram_req ? rd_data_i[{cnt_q, 3'b000} +: 8] : 8'h00;
    stall_req   = ~rst & mem_op & (state_q != DONE);
    rd_addr_o   = rst ? 5'd0 : rd_addr_i;
    rd_enable_o = ~rst & rd_enable_i & ~store_enable;
    if (rst)                  rd_data_o = '0;
    else if (state_q == DONE) rd_data_o = load_enable ? ld_res : '0;
    else                      rd_data_o = rd_data_i;
    mem_fw      = rd_enable_o & ~stall_req;
    mem_fw_addr = rd_addr_o;
    mem_fw_data = rd_data_o;
  end

endmodule

// File: tb/tb_mem.sv
// Directed testbench for the mem stage: pass-through, loads, stores, wait states and reset.
module tb_mem;

  localparam logic [3:0] EXE_LB  = 4'd0;
  localparam logic [3:0] EXE_LH  = 4'd1;
  localparam logic [3:0] EXE_LW  = 4'd2;
  localparam logic [3:0] EXE_LBU = 4'd3;
  localparam logic [3:0] EXE_SH  = 4'd6;

`ifdef MEM_EARLY_REQ_EN
  localparam int EXTRA = 0;
`else
  localparam int EXTRA = 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] rd_data_i;
  logic [4:0]  rd_addr_i;
  logic        rd_enable_i;
  logic        load_enable;
  logic        store_enable;
  logic [31:0] mem_addr_i;
  logic [3:0]  load_store_type;
  logic [7:0]  ram_rdata;
  logic        ram_ready;
  logic        ram_req;
  logic        ram_wr;
  logic [31:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic [31:0] rd_data_o;
  logic [4:0]  rd_addr_o;
  logic        rd_enable_o;
  logic        stall_req;
  logic        mem_fw;
  logic [4:0]  mem_fw_addr;
  logic [31:0] mem_fw_data;

  logic [7:0]  tb_ram [0:4095];
  logic [31:0] acc_addr[$];
  logic [7:0]  acc_wdata[$];
  logic        acc_wr[$];
  logic [31:0] held_addr[$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign ram_rdata = tb_ram[ram_addr[11:0]];

  mem dut (
    .clk(clk), .rst(rst),
    .rd_data_i(rd_data_i), .rd_addr_i(rd_addr_i), .rd_enable_i(rd_enable_i),
    .load_enable(load_enable), .store_enable(store_enable),
    .mem_addr_i(mem_addr_i), .load_store_type(load_store_type),
    .ram_rdata(ram_rdata), .ram_ready(ram_ready),
    .ram_req(ram_req), .ram_wr(ram_wr), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .rd_data_o(rd_data_o), .rd_addr_o(rd_addr_o), .rd_enable_o(rd_enable_o),
    .stall_req(stall_req), .mem_fw(mem_fw), .mem_fw_addr(mem_fw_addr),
    .mem_fw_data(mem_fw_data)
  );

  // Drives one instruction from just after a rising edge and logs each accepted byte
  // until stall_req drops; wait_byte/wait_len insert ram_ready=0 cycles on one byte.
  task automatic run_op(input logic ld, input logic st, input logic [3:0] typ,
                        input logic [31:0] addr, input logic [31:0] data,
                        input logic [4:0] rd, input logic en,
                        input int wait_byte, input int wait_len,
                        output int stalls, output logic [31:0] res, output logic fw,
                        output logic [31:0] fw_data, output logic en_seen,
                        output logic timeout);
    int k;
    int waited;
    k = 0;
    waited = 0;
    acc_addr.delete();
    acc_wdata.delete();
    acc_wr.delete();
    held_addr.delete();
    load_enable = ld;
    store_enable = st;
    load_store_type = typ;
    mem_addr_i = addr;
    rd_data_i = data;
    rd_addr_i = rd;
    rd_enable_i = en;
    ram_ready = 1'b1;
    stalls = 0;
    res = '0;
    fw = 1'b0;
    fw_data = '0;
    en_seen = 1'b0;
    timeout = 1'b1;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      if (rd_enable_o) en_seen = 1'b1;
      if (!stall_req) begin
        res = rd_data_o;
        fw = mem_fw;
        fw_data = mem_fw_data;
        timeout = 1'b0;
        break;
      end
      stalls++;
      if (ram_req) begin
        if (k == wait_byte && waited < wait_len) begin
          ram_ready = 1'b0;
          waited++;
          held_addr.push_back(ram_addr);
        end else begin
          ram_ready = 1'b1;
          acc_addr.push_back(ram_addr);
          acc_wdata.push_back(ram_wdata);
          acc_wr.push_back(ram_wr);
          k++;
        end
      end else begin
        ram_ready = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    load_enable = 1'b0;
    store_enable = 1'b0;
    rd_enable_i = 1'b0;
    ram_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rd_data_i = 32'h0000_1234;
    rd_addr_i = 5'd5;
    rd_enable_i = 1'b1;
    load_enable = 1'b1;
    mem_addr_i = 32'h100;
    #12;
    checks++; if (rd_data_o !== 32'h0) begin errors++; $display("FAIL reset_rd_data: got %h expected 00000000", rd_data_o); end
    checks++; if (ram_req !== 1'b0) begin errors++; $display("FAIL reset_ram_req: got %b expected 0", ram_req); end
    checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall_req); end
    checks++; if (mem_fw !== 1'b0 || rd_addr_o !== 5'd0 || rd_enable_o !== 1'b0) begin
      errors++; $display("FAIL reset_fw: got fw=%b addr=%0d en=%b expected 0/0/0", mem_fw, rd_addr_o, rd_enable_o);
    end
    load_enable = 1'b0;
    rd_enable_i = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    $display("reset: outputs held at zero");
  endtask

  task automatic test_passthrough();
    rd_data_i = 32'h0000_1234;
    rd_addr_i = 5'd5;
    rd_enable_i = 1'b1;
    #1;
    checks++; if (rd_data_o !== 32'h0000_1234) begin errors++; $display("FAIL pass_data: got %h expected 00001234", rd_data_o); end
    checks++; if (mem_fw !== 1'b1) begin errors++; $display("FAIL pass_fw: got %b expected 1", mem_fw); end
    checks++; if (mem_fw_addr !== 5'd5) begin errors++; $display("FAIL pass_fw_addr: got %0d expected 5", mem_fw_addr); end
    checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL pass_stall: got %b expected 0", stall_req); end
    checks++; if (mem_fw_data !== 32'h0000_1234) begin errors++; $display("FAIL pass_fw_data: got %h expected 00001234", mem_fw_data); end
    $display("pass-through: data=%h fw=%b fw_addr=%0d", rd_data_o, mem_fw, mem_fw_addr);
    rd_enable_i = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_lb();
    int st; logic [31:0] r; logic fw; logic [31:0] fd; logic en; logic to;
    run_op(1, 0, EXE_LB, 32'h100, 32'h0, 5'd7, 1, -1, 0, st, r, fw, fd, en, to);
    checks++; if (to || r !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_data: got %h expected ffffff80", r); end
    checks++; if (st != 1 + EXTRA) begin errors++; $display("FAIL lb_stall: got %0d expected %0d", st, 1 + EXTRA); end
    checks++; if (fw !== 1'b1 || fd !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_fw: got fw=%b data=%h expected 1/ffffff80", fw, fd); end
    $display("LB 0x100: data=%h stall=%0d", r, st);
    run_op(1, 0, EXE_LBU, 32'h100, 32'h0, 5'd7, 1, -1, 0, st, r, fw, fd, en, to);
    checks++; if (to || r !== 32'h0000_0080) begin errors++; $display("FAIL lbu_data: got %h expected 00000080", r); end
    checks++; if (st != 1 + EXTRA) begin errors++; $display("FAIL lbu_stall: got %0d expected %0d", st, 1 + EXTRA); end
    $display("LBU 0x100: data=%h stall=%0d", r, st);
  endtask

  task automatic test_lw();
    int st; logic [31:0] r; logic fw; logic [31:0] fd; logic en; logic to;
    logic [31:0] exp_a [4];
    exp_a = '{32'h200, 32'h201, 32'h202, 32'h203};
    run_op(1, 0, EXE_LW, 32'h200, 32'h0, 5'd3, 1, -1, 0, st, r, fw, fd, en, to);
    checks++; if (acc_addr.size() != 4) begin
      errors++; $display("FAIL lw_nbytes: got %0d expected 4", acc_addr.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++; if (acc_addr[i] !== exp_a[i]) begin errors++; $display("FAIL lw_addr[%0d]: got %h expected %h", i, acc_addr[i], exp_a[i]); end
      end
    end
    checks++; if (to || r !== 32'h4433_2211) begin errors++; $display("FAIL lw_data: got %h expected 44332211", r); end
    checks++; if (st != 4 + EXTRA) begin errors++; $display("FAIL lw_stall: got %0d expected %0d", st, 4 + EXTRA); end
    $display("LW 0x200: data=%h stall=%0d", r, st);
  endtask

  task automatic test_sh();
    int st; logic [31:0] r; logic fw; logic [31:0] fd; logic en; logic to;
    run_op(0, 1, EXE_SH, 32'h301, 32'hAABB_CCDD, 5'd4, 1, -1, 0, st, r, fw, fd, en, to);
    checks++; if (acc_addr.size() != 2) begin
      errors++; $display("FAIL sh_nbytes: got %0d expected 2", acc_addr.size());
    end else begin
      checks++; if (acc_addr[0] !== 32'h301 || acc_wdata[0] !== 8'hDD) begin errors++; $display("FAIL sh_byte0: got %h@%h expected dd@00000301", acc_wdata[0], acc_addr[0]); end
      checks++; if (acc_addr[1] !== 32'h302 || acc_wdata[1] !== 8'hCC) begin errors++; $display("FAIL sh_byte1: got %h@%h expected cc@00000302", acc_wdata[1], acc_addr[1]); end
      checks++; if (acc_wr[0] !== 1'b1 || acc_wr[1] !== 1'b1) begin errors++; $display("FAIL sh_wr: got %b%b expected 11", acc_wr[0], acc_wr[1]); end
    end
    checks++; if (en !== 1'b0) begin errors++; $display("FAIL sh_rd_enable: got %b expected 0", en); end
    checks++; if (to || r !== 32'h0 || fw !== 1'b0) begin errors++; $display("FAIL sh_result: got %h fw=%b expected 00000000 fw=0", r, fw); end
    checks++; if (st != 2 + EXTRA) begin errors++; $display("FAIL sh_stall: got %0d expected %0d", st, 2 + EXTRA); end
    $display("SH 0x301: bytes=%0d stall=%0d", acc_addr.size(), st);
  endtask

  task automatic test_lh_wait();
    int st; logic [31:0] r; logic fw; logic [31:0] fd; logic en; logic to;
    run_op(1, 0, EXE_LH, 32'h400, 32'h0, 5'd8, 1, 1, 3, st, r, fw, fd, en, to);
    checks++; if (held_addr.size() != 3) begin
      errors++; $display("FAIL lh_wait_cycles: got %0d expected 3", held_addr.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++; if (held_addr[i] !== 32'h401) begin errors++; $display("FAIL lh_hold_addr[%0d]: got %h expected 00000401", i, held_addr[i]); end
      end
    end
    checks++; if (to || r !== 32'hFFFF_8A7F) begin errors++; $display("FAIL lh_data: got %h expected ffff8a7f", r); end
    checks++; if (st != 2 + EXTRA + 3) begin errors++; $display("FAIL lh_stall: got %0d expected %0d", st, 5 + EXTRA); end
    $display("LH 0x400 with waits: data=%h stall=%0d", r, st);
  endtask

  task automatic test_reset_mid();
    int st; logic [31:0] r; logic fw; logic [31:0] fd; logic en; logic to;
    logic hit;
    hit = 1'b0;
    load_enable = 1'b1;
    store_enable = 1'b0;
    load_store_type = EXE_LW;
    mem_addr_i = 32'h200;
    rd_data_i = 32'h0;
    rd_addr_i = 5'd9;
    rd_enable_i = 1'b1;
    ram_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (ram_req && ram_addr == 32'h202) begin hit = 1'b1; break; end
    end
    checks++; if (!hit) begin errors++; $display("FAIL rstmid_reach_byte2: got 0 expected 1"); end
    rst = 1'b1;
    #1;
    checks++; if (ram_req !== 1'b0 || stall_req !== 1'b0) begin errors++; $display("FAIL rstmid_req: got req=%b stall=%b expected 0/0", ram_req, stall_req); end
    checks++; if (rd_data_o !== 32'h0 || mem_fw !== 1'b0 || rd_enable_o !== 1'b0 || ram_addr !== 32'h0) begin
      errors++; $display("FAIL rstmid_outputs: got data=%h fw=%b en=%b addr=%h expected all 0", rd_data_o, mem_fw, rd_enable_o, ram_addr);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_op(1, 0, EXE_LW, 32'h200, 32'h0, 5'd9, 1, -1, 0, st, r, fw, fd, en, to);
    checks++; if (acc_addr.size() != 4 || acc_addr[0] !== 32'h200) begin errors++; $display("FAIL rstmid_restart: got %0d bytes first=%h expected 4 bytes first=00000200", acc_addr.size(), acc_addr.size() > 0 ? acc_addr[0] : 32'h0); end
    checks++; if (to || r !== 32'h4433_2211) begin errors++; $display("FAIL rstmid_data: got %h expected 44332211", r); end
    checks++; if (st != 4 + EXTRA) begin errors++; $display("FAIL rstmid_stall: got %0d expected %0d", st, 4 + EXTRA); end
    $display("LW reset mid-transfer then restart: data=%h stall=%0d", r, st);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) tb_ram[i] = 8'h00;
    tb_ram[12'h100] = 8'h80;
    tb_ram[12'h200] = 8'h11;
    tb_ram[12'h201] = 8'h22;
    tb_ram[12'h202] = 8'h33;
    tb_ram[12'h203] = 8'h44;
    tb_ram[12'h400] = 8'h7F;
    tb_ram[12'h401] = 8'h8A;
    rst = 1'b1;
    rd_data_i = '0;
    rd_addr_i = '0;
    rd_enable_i = 1'b0;
    load_enable = 1'b0;
    store_enable = 1'b0;
    mem_addr_i = '0;
    load_store_type = EXE_LB;
    ram_ready = 1'b1;
    test_reset();
    test_passthrough();
    test_lb();
    test_lw();
    test_sh();
    test_lh_wait();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
